// File: rtl/axilite_gpio_in_responder.sv
// AXI4-Lite input-GPIO responder: synchronises external pins, exposes them as
// a readable DATA register, latches programmable edges into IRQ_PEND and
// drives a level interrupt from IRQ_PEND & IRQ_EN.
// Optional per-pin debounce filter: define GPIO_IN_DEBOUNCE_EN.
// Register window (32 bytes, word aligned):
//   0x00 DATA (RO), 0x04 IRQ_EN (RW), 0x08 IRQ_PEND (RW1C), 0x0C EDGE_SEL (RW)
module axilite_gpio_in_responder #(
    parameter int NUM_GPIO        = 16,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_GPIO-1:0]   gpio_i,
    output logic                  int_o,
    input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr_i,
    input  logic                  s_axilite_awvalid_i,
    output logic                  s_axilite_awready_o,
    input  logic [31:0]           s_axilite_wdata_i,
    input  logic [3:0]            s_axilite_wstrb_i,
    input  logic                  s_axilite_wvalid_i,
    output logic                  s_axilite_wready_o,
    output logic [1:0]            s_axilite_bresp_o,
    output logic                  s_axilite_bvalid_o,
    input  logic                  s_axilite_bready_i,
    input  logic [ADDR_WIDTH-1:0] s_axilite_araddr_i,
    input  logic                  s_axilite_arvalid_i,
    output logic                  s_axilite_arready_o,
    output logic [31:0]           s_axilite_rdata_o,
    output logic [1:0]            s_axilite_rresp_o,
    output logic                  s_axilite_rvalid_o,
    input  logic                  s_axilite_rready_i
);

    localparam logic [4:0] OFF_DATA    = 5'h00;
    localparam logic [4:0] OFF_EN      = 5'h04;
    localparam logic [4:0] OFF_PEND    = 5'h08;
    localparam logic [4:0] OFF_EDGE    = 5'h0C;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_e;

    wr_state_e wr_state_q;
    rd_state_e rd_state_q;

    logic [NUM_GPIO-1:0] sync1_q, sync2_q, prev_q, data_w;
    logic [NUM_GPIO-1:0] en_q, en_d, pend_q, pend_d, edge_q, edge_d;
    logic [NUM_GPIO-1:0] rise, fall, evt, w1c, wmask, wdat;
    logic [31:0]         wmask32;
    logic                int_q;

    logic                awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [31:0]         rdata_q;

    logic [4:0]          wr_off, rd_off;
    logic                wr_err, wr_commit, rd_err;
    logic [31:0]         rd_data;

    // Two-flop synchroniser on the raw pins
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_GPIO-1:0] deb_q;
    logic [CNT_W-1:0]    cnt_q [NUM_GPIO];

    // Per-pin filter: adopt the synchronised value only after it has differed
    // from the filtered value for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            deb_q <= '0;
            for (int i = 0; i < NUM_GPIO; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign data_w = deb_q;
`else
    assign data_w = sync2_q;
`endif

    assign rise = data_w & ~prev_q;
    assign fall = ~data_w & prev_q;
    assign evt  = (edge_q & rise) | (~edge_q & fall);

    // Write decode; the commit happens during the single ACK cycle while the
    // master still holds AW/W valid
    assign wr_off    = s_axilite_awaddr_i[4:0];
    assign wr_err    = (wr_off[1:0] != 2'b00) || wr_off[4] || (wr_off == OFF_DATA);
    assign wr_commit = (wr_state_q == WR_ACK) && !wr_err;
    assign wmask32   = {{8{s_axilite_wstrb_i[3]}}, {8{s_axilite_wstrb_i[2]}},
                        {8{s_axilite_wstrb_i[1]}}, {8{s_axilite_wstrb_i[0]}}};
    assign wmask     = wmask32[NUM_GPIO-1:0];
    assign wdat      = s_axilite_wdata_i[NUM_GPIO-1:0];

    // Next-state of the register file; a new edge overrides a same-cycle W1C
    always_comb begin
        en_d   = en_q;
        edge_d = edge_q;
        w1c    = '0;
        if (wr_commit) begin
            case (wr_off)
                OFF_EN:   en_d   = (en_q & ~wmask) | (wdat & wmask);
                OFF_PEND: w1c    = wdat & wmask;
                OFF_EDGE: edge_d = (edge_q & ~wmask) | (wdat & wmask);
                default:  ;
            endcase
        end
        pend_d = (pend_q & ~w1c) | evt;
    end

    // Register file, edge-detect history and registered interrupt
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= '0;
            en_q   <= '0;
            pend_q <= '0;
            edge_q <= '0;
            int_q  <= 1'b0;
        end else begin
            prev_q <= data_w;
            en_q   <= en_d;
            pend_q <= pend_d;
            edge_q <= edge_d;
            int_q  <= |(pend_q & en_q);
        end
    end

    // Write channel FSM: accept only when AW and W are presented together
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (s_axilite_awvalid_i && s_axilite_wvalid_i) begin
                        wr_state_q <= WR_ACK;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                WR_ACK: begin
                    awready_q  <= 1'b0;
                    wready_q   <= 1'b0;
                    bvalid_q   <= 1'b1;
                    bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
                    wr_state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axilite_bready_i) begin
                        bvalid_q   <= 1'b0;
                        bresp_q    <= RESP_OKAY;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    assign rd_off = s_axilite_araddr_i[4:0];

    // Read mux; registers are sampled before any same-cycle write lands
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        if ((rd_off[1:0] != 2'b00) || rd_off[4]) begin
            rd_err = 1'b1;
        end else begin
            case (rd_off[3:2])
                2'd0:    rd_data = 32'(data_w);
                2'd1:    rd_data = 32'(en_q);
                2'd2:    rd_data = 32'(pend_q);
                default: rd_data = 32'(edge_q);
            endcase
        end
    end

    // Read channel FSM: capture data in ACK, hold it until rready
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (s_axilite_arvalid_i) begin
                        rd_state_q <= RD_ACK;
                        arready_q  <= 1'b1;
                    end
                end
                RD_ACK: begin
                    arready_q  <= 1'b0;
                    rvalid_q   <= 1'b1;
                    rdata_q    <= rd_data;
                    rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
                    rd_state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (s_axilite_rready_i) begin
                        rvalid_q   <= 1'b0;
                        rdata_q    <= '0;
                        rresp_q    <= RESP_OKAY;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign int_o               = int_q;
    assign s_axilite_awready_o = awready_q;
    assign s_axilite_wready_o  = wready_q;
    assign s_axilite_bvalid_o  = bvalid_q;
    assign s_axilite_bresp_o   = bresp_q;
    assign s_axilite_arready_o = arready_q;
    assign s_axilite_rvalid_o  = rvalid_q;
    assign s_axilite_rresp_o   = rresp_q;
    assign s_axilite_rdata_o   = rdata_q;

    // Address bits above the window, data bits above NUM_GPIO and the width
    // parameters are intentionally not decoded
    logic        unused_bits;
    logic [31:0] unused_par;
    assign unused_bits = ^{s_axilite_awaddr_i, s_axilite_araddr_i, s_axilite_wdata_i, wmask32};
    assign unused_par  = 32'(DATA_WIDTH) ^ 32'(DEBOUNCE_CYCLES);

endmodule

// File: tb/tb_axilite_gpio_in_responder.sv
module tb_axilite_gpio_in_responder;

    localparam int DB_CYC = 8;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT = DB_CYC + 4;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] gpio;
    logic        int_o;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    rsp_t        rd_q[$];
    logic [1:0]  wr_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axilite_gpio_in_responder #(
        .NUM_GPIO(16), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEBOUNCE_CYCLES(DB_CYC)
    ) dut (
        .clock_i(clk), .reset_i(rst), .gpio_i(gpio), .int_o(int_o),
        .s_axilite_awaddr_i(awaddr), .s_axilite_awvalid_i(awvalid), .s_axilite_awready_o(awready),
        .s_axilite_wdata_i(wdata), .s_axilite_wstrb_i(wstrb),
        .s_axilite_wvalid_i(wvalid), .s_axilite_wready_o(wready),
        .s_axilite_bresp_o(bresp), .s_axilite_bvalid_o(bvalid), .s_axilite_bready_i(bready),
        .s_axilite_araddr_i(araddr), .s_axilite_arvalid_i(arvalid), .s_axilite_arready_o(arready),
        .s_axilite_rdata_o(rdata), .s_axilite_rresp_o(rresp),
        .s_axilite_rvalid_o(rvalid), .s_axilite_rready_i(rready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        rsp_t e;
        int   n;
        rd_q.push_back({exp_data, exp_resp});
        @(posedge clk); #1;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        check_val({tag, "_arready"}, 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        check_val({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        e = rd_q.pop_front();
        check_val({tag, "_rdata"}, rdata, e.data);
        check_val({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] e;
        int         n;
        wr_q.push_back(exp_resp);
        @(posedge clk); #1;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(posedge clk); #1; n++; end
        check_val({tag, "_awready"}, 32'(awready && wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        e = wr_q.pop_front();
        check_val({tag, "_bresp"}, 32'({bvalid, bresp}), 32'({1'b1, e}));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;
        logic [1:0] held;
        int n;

        rst = 1'b1; gpio = 16'hFFFF;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        wait_cycles(3);
        check_val("reset_ctl", 32'({awready, wready, bvalid, bresp, arready, rvalid, rresp, int_o}), 32'd0);
        check_val("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        wait_cycles(LAT);
        axi_read("data_after_reset", 32'h00, 32'h0000FFFF, 2'b00);

        // rising-edge interrupt on bit 0
        axi_write("en_bit0", 32'h04, 32'h1, 4'hF, 2'b00);
        axi_write("edge_bit0", 32'h0C, 32'h1, 4'hF, 2'b00);
        axi_read("pend_idle", 32'h08, 32'h0, 2'b00);
        gpio[0] = 1'b0;
        wait_cycles(4 + LAT);
        gpio[0] = 1'b1;
        wait_cycles(4 + LAT);
        axi_read("pend_rise0", 32'h08, 32'h1, 2'b00);
        check_val("int_set", 32'(int_o), 32'd1);
        axi_write("w1c_bit0", 32'h08, 32'h1, 4'hF, 2'b00);
        check_val("int_cleared", 32'(int_o), 32'd0);

        // falling-edge on bit 3
        gpio[3] = 1'b0;
        wait_cycles(4 + LAT);
        axi_read("pend_fall3", 32'h08, 32'h8, 2'b00);
        gpio[3] = 1'b1;
        wait_cycles(4 + LAT);
        axi_read("pend_rise3_ignored", 32'h08, 32'h8, 2'b00);
`ifndef GPIO_IN_DEBOUNCE_EN
        // new falling edge lands in the same cycle as the W1C commit
        @(posedge clk); #1;
        gpio[3] = 1'b0;
        axi_write("w1c_vs_edge", 32'h08, 32'h8, 4'hF, 2'b00);
        axi_read("pend_set_wins", 32'h08, 32'h8, 2'b00);
`else
        gpio[3] = 1'b0;
        wait_cycles(4 + LAT);
`endif
        axi_write("w1c_bit3", 32'h08, 32'h8, 4'hF, 2'b00);
        axi_read("pend_cleared", 32'h08, 32'h0, 2'b00);

        // error responses and byte strobes
        axi_read("rd_unmapped", 32'h14, 32'h0, 2'b10);
        axi_read("rd_misaligned", 32'h02, 32'h0, 2'b10);
        axi_write("wr_data_ro", 32'h00, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_read("data_unchanged", 32'h00, 32'h0000FFF7, 2'b00);
        axi_write("wr_unmapped", 32'h18, 32'hFFFF_FFFF, 4'hF, 2'b10);
        axi_write("en_zero", 32'h04, 32'h0, 4'hF, 2'b00);
        axi_write("en_strb", 32'h04, 32'h0000FFFF, 4'b0010, 2'b00);
        axi_read("en_strb_rb", 32'h04, 32'h0000FF00, 2'b00);
        axi_read("edge_unchanged", 32'h0C, 32'h1, 2'b00);

        // AW ahead of W, slow bready
        wr_q.push_back(2'b00);
        @(posedge clk); #1;
        awaddr = 32'h0C; awvalid = 1'b1; wvalid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (awready || wready) bad = 1'b1;
        end
        check_val("aw_alone_no_ready", 32'(bad), 32'd0);
        wdata = 32'h3; wstrb = 4'hF; wvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("aw_w_ready", 32'(awready && wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        held = bresp;
        bad = !bvalid;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!bvalid || bresp !== held) bad = 1'b1;
        end
        check_val("b_held_stable", 32'(bad), 32'd0);
        check_val("b_held_resp", 32'(held), 32'(wr_q.pop_front()));
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_val("b_dropped", 32'(bvalid), 32'd0);
        axi_read("edge_slow_b", 32'h0C, 32'h3, 2'b00);

`ifdef GPIO_IN_DEBOUNCE_EN
        // short glitch on bit 5 is filtered, a long level passes
        gpio[5] = 1'b0;
        wait_cycles(5);
        gpio[5] = 1'b1;
        wait_cycles(20);
        axi_read("db_glitch_data", 32'h00, 32'h0000FFF7, 2'b00);
        axi_read("db_glitch_pend", 32'h08, 32'h0, 2'b00);
        gpio[5] = 1'b0;
        wait_cycles(12);
        axi_read("db_level_data", 32'h00, 32'h0000FFD7, 2'b00);
        axi_read("db_level_pend", 32'h08, 32'h20, 2'b00);
`else
        // change becomes visible on the second edge: read issued right away
        @(posedge clk); #1;
        gpio = 16'hA5F0;
        axi_read("data_latency", 32'h00, 32'h0000A5F0, 2'b00);
`endif

        // reset in the middle of a read aborts it
        @(posedge clk); #1;
        araddr = 32'h0C; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        check_val("abort_arready", 32'(arready), 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_rst_ctl", 32'({arready, rvalid, int_o}), 32'd0);
        wait_cycles(2);
        arvalid = 1'b0;
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rvalid || bvalid) bad = 1'b1;
        end
        check_val("abort_no_resp", 32'(bad), 32'd0);
        axi_read("edge_after_reset", 32'h0C, 32'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
